board_data_ctrl: RTL
====================

Name: board_data_ctrl

Overview:
- Synchronous controller between the raw board inputs (switches, push-buttons) and the 7-segment display driver.
- Synchronises and debounces every button, then turns clean press edges into commands on a DATA_W-bit display register: load, clear, increment, decrement, rotate, and display-enable toggle.
- Increment/decrement auto-repeat while held.
- Everything runs on clk; no logic is clocked by button signals.

Parameters:
DATA_W, 32, width of switch input and data register
NBTN, 6, number of buttons (must be >= 6; only indices 0..5 carry commands)
DEBOUNCE_CYCLES, 200000, consecutive stable clocks required to accept a level change (10 ms at 20 MHz)
STEP, 1, increment/decrement amount (< 2^DATA_W)
REPEAT_DELAY, 10000000, hold clocks before first auto-repeat (0 disables auto-repeat)
REPEAT_PERIOD, 2000000, clocks between subsequent auto-repeats (>= 1)

Ports:
clk  in  1  system clock, 20 MHz
rst  in  1  reset, asynchronous, active-high
sw  in  DATA_W  switch bank, used as load value; assumed quasi-static
btn  in  NBTN  raw push-buttons, asynchronous, active-high, bouncy
data  out  DATA_W  display register, feeds display data input
disp_en  out  1  display enable, feeds display enable input
btn_level  out  NBTN  debounced button levels
btn_pulse  out  NBTN  one-clock pulse on each debounced rising edge
wrap  out  1  one-clock pulse when an inc/dec wraps

Behaviour:
- Reset (async assert, sync release): data=0, disp_en=1, btn_level=0, btn_pulse=0, wrap=0. Synchronisers, debounce counters and repeat timers are cleared.
- Synchroniser: 2-FF per button, reset 0.
- Debounce, per button:
  - Counter clears whenever the synced input equals btn_level[i].
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES, btn_level[i] flips and the counter clears.
  - Counter width is clog2(DEBOUNCE_CYCLES+1).
  - A glitch shorter than DEBOUNCE_CYCLES never changes the level.
- Latency: raw edge to btn_level change is DEBOUNCE_CYCLES+2 clocks (+1 for async sampling).
- btn_pulse[i] is high for exactly the clock after btn_level[i] rises 0->1. Releases produce no pulse.
- Command map (pulse-driven, registered; data updates the clock after the pulse):
  - btn[0]: data <= sw
  - btn[1]: disp_en <= ~disp_en
  - btn[2]: data <= data + STEP
  - btn[3]: data <= data - STEP
  - btn[4]: data <= {data[DATA_W-2:0], data[DATA_W-1]} (rotate left)
  - btn[5]: data <= 0
  - btn[NBTN-1:6]: pulses/levels only
- Simultaneous commands in one clock, by priority: load > clear > inc/dec > rotate.
  - inc and dec together: no data change, no wrap.
  - disp_en toggle is independent of the data commands.
- Arithmetic is modulo 2^DATA_W.
  - wrap pulses one clock, coincident with the data update, when an executed inc carries out or an executed dec borrows.
  - wrap is never raised by load, clear or rotate, nor by an inc/dec suppressed by priority.
- Auto-repeat (inc and dec only, when REPEAT_DELAY != 0):
  - Per-button repeat timer starts at the press pulse.
  - After REPEAT_DELAY clocks of continuous btn_level high, one extra command event fires, then one every REPEAT_PERIOD clocks.
  - The timer clears when the level falls.
  - Repeat events obey the same priority and wrap rules as pulses but do not assert btn_pulse.
- Reset mid-hold: a button still held at reset release must re-debounce from level 0 and then produces a fresh pulse/command.

Test Plan:
(Sim params: DATA_W=8, DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=4, STEP=1.)
- Reset, then sw=0xA5 and btn[0] held clean -> btn_level[0] rises within 6-7 clocks; btn_pulse[0] for 1 clock; data=0xA5 next clock; wrap=0.
- Bounce btn[2] (3-clock high, 1 low, repeated), then hold 5 clocks -> exactly one btn_pulse[2]; data increments once.
- data=0xFF, press btn[2] -> data=0x00 and wrap=1 for one clock. data=0x00, press btn[3] -> data=0xFF and wrap=1.
- Hold btn[2] from data=0x10 for 8+3*4 clocks after the pulse -> increments at pulse, +8, +12, +16, +20 clocks → data=0x15. Release -> no further change; btn_pulse[2] asserted only once.
- Pulses on btn[0], btn[5] and btn[2] in the same clock with sw=0x3C -> data=0x3C, wrap=0. btn[2] and btn[3] together -> data unchanged. btn[1] pulse -> disp_en 1->0; again -> 1.
- Hold btn[4] with data=0x81, assert rst mid-hold -> data=0 and disp_en=1 immediately. After release with btn[4] still held -> new pulse after debounce; data=0x00 after rotate. Repeat with data loaded to 0x81 -> 0x03.

Source files
------------

// File: rtl/board_data_ctrl.sv
// Board input controller: synchronises and debounces push-buttons, turns clean
// press edges (plus inc/dec auto-repeat) into commands on a display register,
// and drives the display enable.
module board_data_ctrl #(
    parameter int DATA_W          = 32,
    parameter int NBTN            = 6,
    parameter int DEBOUNCE_CYCLES = 200000,
    parameter int STEP            = 1,
    parameter int REPEAT_DELAY    = 10000000,
    parameter int REPEAT_PERIOD   = 2000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] sw,
    input  logic [NBTN-1:0]   btn,
    output logic [DATA_W-1:0] data,
    output logic              disp_en,
    output logic [NBTN-1:0]   btn_level,
    output logic [NBTN-1:0]   btn_pulse,
    output logic              wrap
);

    // Debounce counter sized to hold DEBOUNCE_CYCLES; it flips the level on
    // the clock that would take it to DEBOUNCE_CYCLES, so the last stored
    // value is DEBOUNCE_CYCLES-1.
    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Repeat timer counts clocks since the press pulse (or since the last
    // repeat event) and must reach the larger of the two intervals.
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TMR_W   = $clog2(RPT_MAX + 1);
    localparam logic             RPT_EN     = (REPEAT_DELAY != 0);
    localparam logic [TMR_W-1:0] TMR_DELAY  = TMR_W'(REPEAT_DELAY);
    localparam logic [TMR_W-1:0] TMR_PERIOD = TMR_W'(REPEAT_PERIOD);

    localparam logic [DATA_W-1:0] STEP_V = DATA_W'(STEP);

    logic [NBTN-1:0]   sync1_r;
    logic [NBTN-1:0]   sync2_r;
    logic [CNT_W-1:0]  db_cnt_r [NBTN];
    logic [NBTN-1:0]   level_d_r;

    // Index 0 follows the increment button, index 1 the decrement button.
    logic [TMR_W-1:0]  tmr_r [2];
    logic [1:0]        rpt_first_r;
    logic [1:0]        rpt_act_r;
    logic [1:0]        rep_ev_s;

    logic              inc_s;
    logic              dec_s;
    logic [DATA_W:0]   sum_s;
    logic [DATA_W:0]   diff_s;
    logic [DATA_W-1:0] data_nx_s;
    logic              wrap_nx_s;

    // Two-flop synchroniser bringing each raw button into the clk domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r <= '0;
            sync2_r <= '0;
        end else begin
            sync1_r <= btn;
            sync2_r <= sync1_r;
        end
    end

    // Per-button debounce: count consecutive disagreeing samples, flip level when the run is long enough.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NBTN; i++) begin
                db_cnt_r[i] <= '0;
            end
            btn_level <= '0;
        end else begin
            for (int i = 0; i < NBTN; i++) begin
                if (sync2_r[i] == btn_level[i]) begin
                    db_cnt_r[i] <= '0;
                end else if (db_cnt_r[i] == CNT_LAST) begin
                    db_cnt_r[i]  <= '0;
                    btn_level[i] <= ~btn_level[i];
                end else begin
                    db_cnt_r[i] <= db_cnt_r[i] + CNT_W'(1);
                end
            end
        end
    end

    // Rising-edge detector on the debounced levels; pulse appears the clock after the level rises.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_d_r <= '0;
            btn_pulse <= '0;
        end else begin
            level_d_r <= btn_level;
            btn_pulse <= btn_level & ~level_d_r;
        end
    end

    // Repeat event decode: fires when the held timer hits the first delay, then each period.
    always_comb begin
        rep_ev_s = 2'b00;
        for (int j = 0; j < 2; j++) begin
            if (rpt_act_r[j] && btn_level[2+j]) begin
                if (rpt_first_r[j]) begin
                    rep_ev_s[j] = (tmr_r[j] == TMR_DELAY);
                end else begin
                    rep_ev_s[j] = (tmr_r[j] == TMR_PERIOD);
                end
            end else begin
                rep_ev_s[j] = 1'b0;
            end
        end
    end

    // Auto-repeat timers for inc/dec: armed by the press pulse, cleared when the level drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < 2; j++) begin
                tmr_r[j] <= '0;
            end
            rpt_first_r <= 2'b00;
            rpt_act_r   <= 2'b00;
        end else begin
            for (int j = 0; j < 2; j++) begin
                if (btn_pulse[2+j]) begin
                    tmr_r[j]       <= TMR_W'(1);
                    rpt_first_r[j] <= 1'b1;
                    rpt_act_r[j]   <= RPT_EN;
                end else if (!btn_level[2+j]) begin
                    tmr_r[j]       <= '0;
                    rpt_first_r[j] <= 1'b0;
                    rpt_act_r[j]   <= 1'b0;
                end else if (rep_ev_s[j]) begin
                    tmr_r[j]       <= TMR_W'(1);
                    rpt_first_r[j] <= 1'b0;
                end else if (rpt_act_r[j]) begin
                    tmr_r[j] <= tmr_r[j] + TMR_W'(1);
                end else begin
                    tmr_r[j] <= tmr_r[j];
                end
            end
        end
    end

    // Command arbitration: load > clear > inc/dec > rotate; inc with dec together cancels.
    always_comb begin
        inc_s     = btn_pulse[2] | rep_ev_s[0];
        dec_s     = btn_pulse[3] | rep_ev_s[1];
        sum_s     = {1'b0, data} + {1'b0, STEP_V};
        diff_s    = {1'b0, data} - {1'b0, STEP_V};
        data_nx_s = data;
        wrap_nx_s = 1'b0;
        if (btn_pulse[0]) begin
            data_nx_s = sw;
        end else if (btn_pulse[5]) begin
            data_nx_s = '0;
        end else if (inc_s && dec_s) begin
            data_nx_s = data;
        end else if (inc_s) begin
            data_nx_s = sum_s[DATA_W-1:0];
            wrap_nx_s = sum_s[DATA_W];
        end else if (dec_s) begin
            data_nx_s = diff_s[DATA_W-1:0];
            wrap_nx_s = diff_s[DATA_W];
        end else if (btn_pulse[4]) begin
            data_nx_s = {data[DATA_W-2:0], data[DATA_W-1]};
        end else begin
            data_nx_s = data;
        end
    end

    // Display register and one-clock wrap flag, updated the clock after the command.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data <= '0;
            wrap <= 1'b0;
        end else begin
            data <= data_nx_s;
            wrap <= wrap_nx_s;
        end
    end

    // Display enable toggles on every btn[1] press, independent of data commands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_en <= 1'b1;
        end else if (btn_pulse[1]) begin
            disp_en <= ~disp_en;
        end else begin
            disp_en <= disp_en;
        end
    end

endmodule
